// File: rtl/gpu_pkg.sv
// Shared GPU types: fp32 words, vertex bundles and the
// triangle sequencer state encoding.
package gpu_pkg;

    typedef logic [31:0] fp32_t;
    typedef fp32_t vertex_t [3];

    localparam int WORDS_PER_TRI = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_DONE,
        S_SWAP_WAIT
    } seq_state_t;

endpackage

// File: rtl/triangle_sequencer.sv
// Frame command stage: fetches each triangle's nine fp32 words,
// kicks the rasterizer, then swaps buffers on a vsync falling edge.
module triangle_sequencer
    import gpu_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int START_CYCLES = 4
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              go,
    input  logic [7:0]        tri_count,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] vmem_addr,
    input  logic [31:0]       vmem_rdata,
    output vertex_t           p1,
    output vertex_t           p2,
    output vertex_t           p3,
    output logic              raster_start,
    input  logic              raster_done,
    input  logic              vga_vs,
    output logic              buffer_select,
    output logic              busy,
    output logic              frame_done
);

    localparam int AW_X = ADDR_W + 4;
    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [3:0] I_LAST = 4'd9;

    seq_state_t        state_q, state_d;
    logic [7:0]        t_q, t_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        i_q, i_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              buf_q, buf_d;
    logic              fd_q, fd_d;
    logic              vs_q;
    fp32_t             words_q [WORDS_PER_TRI];
    fp32_t             words_d [WORDS_PER_TRI];

    // Word address of the current fetch, widened so 9t+i cannot
    // overflow before wrapping to the memory size.
    assign vmem_addr = ADDR_W'(AW_X'(base_q)
                     + AW_X'(t_q) * AW_X'(WORDS_PER_TRI)
                     + AW_X'(i_q));

    assign p1 = '{words_q[0], words_q[1], words_q[2]};
    assign p2 = '{words_q[3], words_q[4], words_q[5]};
    assign p3 = '{words_q[6], words_q[7], words_q[8]};

    assign raster_start  = (state_q == S_START);
    assign busy          = (state_q != S_IDLE);
    assign buffer_select = buf_q;
    assign frame_done    = fd_q;

    // Next-state, counters and vertex capture.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        sc_d    = sc_q;
        base_d  = base_q;
        buf_d   = buf_q;
        fd_d    = 1'b0;
        words_d = words_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    cnt_d  = tri_count;
                    base_d = base_addr;
                    t_d    = '0;
                    i_d    = '0;
                    if (tri_count == 8'd0) state_d = S_SWAP_WAIT;
                    else                   state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                for (int k = 0; k < WORDS_PER_TRI; k++) begin
                    if (i_q == 4'(k + 1)) words_d[k] = vmem_rdata;
                end
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    sc_d    = '0;
                    state_d = S_START;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
            S_START: begin
                if (sc_q == SC_LAST) state_d = S_WAIT_DONE;
                else                 sc_d    = sc_q + 1'b1;
            end
            S_WAIT_DONE: begin
                if (raster_done) begin
                    t_d = t_q + 8'd1;
                    i_d = '0;
                    if ({1'b0, t_q} + 9'd1 < {1'b0, cnt_q})
                        state_d = S_FETCH;
                    else
                        state_d = S_SWAP_WAIT;
                end
            end
            S_SWAP_WAIT: begin
                if (vs_q && !vga_vs) begin
                    buf_d   = ~buf_q;
                    fd_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            sc_q    <= '0;
            base_q  <= '0;
            buf_q   <= 1'b0;
            fd_q    <= 1'b0;
            vs_q    <= 1'b0;
            for (int k = 0; k < WORDS_PER_TRI; k++) words_q[k] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            sc_q    <= sc_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
            fd_q    <= fd_d;
            vs_q    <= vga_vs;
            for (int k = 0; k < WORDS_PER_TRI; k++) words_q[k] <= words_d[k];
        end
    end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer with a synchronous
// vertex memory model and hand-driven rasterizer handshake.
module tb_triangle_sequencer;
    import gpu_pkg::*;

    localparam int ADDR_W = 8;
    localparam int SC     = 4;

    logic              clk = 1'b0;
    logic              areset_n;
    logic              go;
    logic [7:0]        tri_count;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] vmem_addr;
    logic [31:0]       vmem_rdata;
    vertex_t           p1, p2, p3;
    logic              raster_start;
    logic              raster_done;
    logic              vga_vs;
    logic              buffer_select;
    logic              busy;
    logic              frame_done;

    fp32_t mem [256];
    int    n_vec = 0;
    int    n_err = 0;
    logic  exp_buf = 1'b0;

    always #5 clk = ~clk;

    // Synchronous vertex memory: data one cycle after address.
    always @(posedge clk) vmem_rdata <= mem[vmem_addr];

    triangle_sequencer #(.ADDR_W(ADDR_W), .START_CYCLES(SC)) dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .go           (go),
        .tri_count    (tri_count),
        .base_addr    (base_addr),
        .vmem_addr    (vmem_addr),
        .vmem_rdata   (vmem_rdata),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .raster_start (raster_start),
        .raster_done  (raster_done),
        .vga_vs       (vga_vs),
        .buffer_select(buffer_select),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fp32_t pword(input int k);
        case (k / 3)
            0:       return p1[k % 3];
            1:       return p2[k % 3];
            default: return p3[k % 3];
        endcase
    endfunction

    task automatic start_frame(input logic [7:0] cnt,
                               input logic [7:0] base);
        go        = 1'b1;
        tri_count = cnt;
        base_addr = base;
        tick();
        go = 1'b0;
    endtask

    // Entered in cycle 1 of FETCH; leaves one cycle after done.
    task automatic do_tri(input logic [7:0] a0, input bit spur);
        logic [7:0] a;
        for (int k = 0; k < 9; k++) begin
            a = a0 + 8'(k);
            chk("addr", 32'(vmem_addr), 32'(a));
            chk("fetch_nostart", 32'(raster_start), 32'd0);
            if (spur && k == 0) begin
                go          = 1'b1;
                tri_count   = 8'd5;
                base_addr   = 8'd100;
                raster_done = 1'b1;
            end
            if (spur && k == 1) go = 1'b0;
            tick();
        end
        chk("pre_start", 32'(raster_start), 32'd0);
        tick();
        for (int s = 0; s < SC; s++) begin
            chk("start", 32'(raster_start), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            tick();
        end
        chk("start_end", 32'(raster_start), 32'd0);
        for (int k = 0; k < 9; k++) begin
            a = a0 + 8'(k);
            chk("pword", pword(k), mem[a]);
        end
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
    endtask

    // Requires vga_vs high in the previous cycle.
    task automatic vs_fall();
        vga_vs = 1'b0;
        chk("fd_pre", 32'(frame_done), 32'd0);
        tick();
        exp_buf = ~exp_buf;
        chk("fd_pulse", 32'(frame_done), 32'd1);
        chk("buf_swap", 32'(buffer_select), 32'(exp_buf));
        chk("busy_drop", 32'(busy), 32'd0);
        tick();
        chk("fd_one", 32'(frame_done), 32'd0);
        chk("buf_hold", 32'(buffer_select), 32'(exp_buf));
        vga_vs = 1'b1;
        tick();
    endtask

    initial begin
        areset_n    = 1'b0;
        go          = 1'b0;
        tri_count   = '0;
        base_addr   = '0;
        raster_done = 1'b0;
        vga_vs      = 1'b1;
        for (int j = 0; j < 256; j++)
            mem[j] = 32'h4100_0000 + 32'(j) * 32'h101;
        mem[0] = 32'h428A0000; mem[1] = 32'h428A0000; mem[2] = 32'h3F800000;
        mem[3] = 32'h428A0000; mem[4] = 32'h43290000; mem[5] = 32'h3F800000;
        mem[6] = 32'h43290000; mem[7] = 32'h428A0000; mem[8] = 32'h3F800000;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(raster_start), 32'd0);
        chk("rst_buf", 32'(buffer_select), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_addr", 32'(vmem_addr), 32'd0);
        chk("rst_p1x", p1[0], 32'd0);
        chk("rst_p3z", p3[2], 32'd0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        tick();

        // Single triangle at base 0.
        start_frame(8'd1, 8'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        do_tri(8'd0, 1'b0);
        chk("t1_p1x", p1[0], 32'h428A0000);
        chk("t1_p2y", p2[1], 32'h43290000);
        chk("t1_p3z", p3[2], 32'h3F800000);
        vs_fall();

        // Three triangles wrapping past address 255.
        start_frame(8'd3, 8'd250);
        do_tri(8'd250, 1'b0);
        do_tri(8'd3, 1'b0);
        do_tri(8'd12, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk("t2_nostart", 32'(raster_start), 32'd0);
            chk("t2_busy", 32'(busy), 32'd1);
            tick();
        end
        vs_fall();

        // Empty frame goes straight to the swap.
        start_frame(8'd0, 8'd5);
        for (int c = 0; c < 4; c++) begin
            chk("t3_nostart", 32'(raster_start), 32'd0);
            chk("t3_busy", 32'(busy), 32'd1);
            tick();
        end
        vs_fall();

        // Spurious done in FETCH/START and go while busy.
        start_frame(8'd1, 8'd20);
        do_tri(8'd20, 1'b1);
        for (int c = 0; c < 6; c++) begin
            chk("t4_nostart", 32'(raster_start), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
            tick();
        end
        vs_fall();

        // Reset during WAIT_DONE.
        start_frame(8'd2, 8'd40);
        for (int c = 0; c < 14; c++) tick();
        chk("t5_wait_busy", 32'(busy), 32'd1);
        chk("t5_wait_nostart", 32'(raster_start), 32'd0);
        areset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_start", 32'(raster_start), 32'd0);
        chk("t5_addr", 32'(vmem_addr), 32'd0);
        chk("t5_buf", 32'(buffer_select), 32'd0);
        chk("t5_fd", 32'(frame_done), 32'd0);
        chk("t5_p1x", p1[0], 32'd0);
        chk("t5_p2y", p2[1], 32'd0);
        exp_buf = 1'b0;
        tick();
        areset_n = 1'b1;
        tick();
        start_frame(8'd1, 8'd40);
        do_tri(8'd40, 1'b0);
        vs_fall();

        // Enter SWAP_WAIT with vsync already low.
        vga_vs = 1'b0;
        tick();
        tick();
        start_frame(8'd1, 8'd60);
        do_tri(8'd60, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("t6_nofd", 32'(frame_done), 32'd0);
            chk("t6_buf", 32'(buffer_select), 32'(exp_buf));
            chk("t6_busy", 32'(busy), 32'd1);
            tick();
        end
        vga_vs = 1'b1;
        tick();
        chk("t6_rise_nofd", 32'(frame_done), 32'd0);
        chk("t6_rise_busy", 32'(busy), 32'd1);
        vs_fall();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
